// File: rtl/data_memory_lsu_if.sv
// Request/response bus of the data memory load/store unit.
// Request handshake: a request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse.
interface data_memory_lsu_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressable RV32I data memory with sized/signed access, zero sweep after reset
// and configurable read latency. Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors.
module data_memory_lsu #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_memory_lsu_if.slave     bus,
  output logic [1:0]           state_o
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                state_q;
  logic [IW-1:0]         sweep_q;
  logic [2:0]            cnt_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  init_done_q;

  logic [31:0]           mem_q [DEPTH];

  logic                  accept;
  logic                  legal;
  logic                  dec_err;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [3:0]            dec_be;
  logic [31:0]           dec_wd;

  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wd;

  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [31:0]           load_data;

  assign accept = (state_q == S_IDLE) && req_ready_q && bus.req_valid;

  // Request decode: legality, effective address, byte enables and lane-replicated store data.
  always_comb begin
    legal    = 1'b0;
    dec_err  = 1'b0;
    addr_eff = bus.req_addr;
    dec_be   = 4'b0000;
    dec_wd   = 32'h0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_we;
      default:                legal = 1'b0;
    endcase
    dec_err = !legal;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])          dec_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) dec_err = 1'b1;
`else
    if (bus.req_funct3[1:0] == 2'b01) addr_eff[0]   = 1'b0;
    if (bus.req_funct3[1:0] == 2'b10) addr_eff[1:0] = 2'b00;
`endif
    case (bus.req_funct3[1:0])
      2'b00: begin
        dec_be = 4'b0001 << addr_eff[1:0];
        dec_wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        dec_be = addr_eff[1] ? 4'b1100 : 4'b0011;
        dec_wd = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        dec_be = 4'b1111;
        dec_wd = bus.req_wdata;
      end
    endcase
  end

  // The clear sweep owns the write port; otherwise stores commit on the acceptance edge.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = addr_eff[ADDR_WIDTH-1:2];
    mem_be  = dec_be;
    mem_wd  = dec_wd;
    if (state_q == S_CLEAR) begin
      mem_we  = 1'b1;
      mem_idx = sweep_q;
      mem_be  = 4'b1111;
      mem_wd  = 32'h0;
    end else if (accept && bus.req_we && !dec_err) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  always_comb begin
    rd_word   = mem_q[addr_q[ADDR_WIDTH-1:2]];
    rd_shift  = rd_word >> {addr_q[1:0], 3'b000};
    load_data = rd_word;
    case (funct3_q[1:0])
      2'b00:   load_data = funct3_q[2] ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = funct3_q[2] ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CLEAR;
      sweep_q     <= '0;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == IW'(DEPTH - 1)) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_WAIT;
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            funct3_q    <= bus.req_funct3;
            addr_q      <= addr_eff;
            err_q       <= dec_err;
            cnt_q       <= bus.req_we ? 3'd1 : 3'(READ_LATENCY);
          end
        end
        S_WAIT: begin
          // cnt_q==1 launches the response pulse; cnt_q==0 retires it and reopens the port.
          if (cnt_q == 3'd1) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (we_q || err_q) ? 32'h0 : load_data;
            rsp_err_q   <= err_q;
            cnt_q       <= 3'd0;
          end else if (cnt_q == 3'd0) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = init_done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: one instance at READ_LATENCY=1, one at READ_LATENCY=3.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v1 = 1'b0;
  logic        v3 = 1'b0;
  logic        t_we = 1'b0;
  logic [2:0]  t_f3 = 3'd0;
  logic [11:0] t_addr = 12'h0;
  logic [31:0] t_wd = 32'h0;
  logic [1:0]  st1;
  logic [1:0]  st3;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  data_memory_lsu_if #(.ADDR_WIDTH(12)) if1 ();
  data_memory_lsu_if #(.ADDR_WIDTH(12)) if3 ();

  assign if1.req_valid  = v1;
  assign if1.req_we     = t_we;
  assign if1.req_funct3 = t_f3;
  assign if1.req_addr   = t_addr;
  assign if1.req_wdata  = t_wd;
  assign if3.req_valid  = v3;
  assign if3.req_we     = t_we;
  assign if3.req_funct3 = t_f3;
  assign if3.req_addr   = t_addr;
  assign if3.req_wdata  = t_wd;

  data_memory_lsu #(.ADDR_WIDTH(12), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave), .state_o(st1)
  );
  data_memory_lsu #(.ADDR_WIDTH(12), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3.slave), .state_o(st3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 1) ? if1.req_ready : if3.req_ready;
  endfunction
  function automatic logic rv_of(input int sel);
    return (sel == 1) ? if1.rsp_valid : if3.rsp_valid;
  endfunction
  function automatic logic [31:0] rd_of(input int sel);
    return (sel == 1) ? if1.rsp_rdata : if3.rsp_rdata;
  endfunction
  function automatic logic er_of(input int sel);
    return (sel == 1) ? if1.rsp_err : if3.rsp_err;
  endfunction

  // One request through the handshake, then check data, error, latency and port occupancy.
  task automatic xact(input int sel, input logic we, input logic [2:0] f3, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input string tag);
    int          n = 0;
    int          lat = 0;
    logic        leak = 1'b0;
    logic [31:0] rd = 32'h0;
    logic        er = 1'b0;
    @(negedge clk);
    while (!rdy_of(sel) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready_wait"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    t_we = we; t_f3 = f3; t_addr = addr; t_wd = wd;
    if (sel == 1) v1 = 1'b1; else v3 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0; v3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (rdy_of(sel)) leak = 1'b1;
      @(posedge clk);
      #1;
      if (rv_of(sel)) begin
        lat = k;
        rd  = rd_of(sel);
        er  = er_of(sel);
        break;
      end
    end
    if (rdy_of(sel)) leak = 1'b1;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rdata"}, rd, exp_rd);
    check_eq({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    check_eq({tag, "_ready_low"}, {31'h0, leak}, 32'h0);
    @(posedge clk);
    #1;
    check_eq({tag, "_rsp_drop"}, {30'h0, rv_of(sel), rdy_of(sel)}, 32'h1);
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!if1.init_done && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int   cyc;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", {27'h0, if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.init_done, if3.init_done}, 32'h0);
    check_eq("rst_rdata", if1.rsp_rdata, 32'h0);
    check_eq("rst_state", {28'h0, st1, st3}, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    wait_init(cyc);
    check_eq("sweep_cycles", 32'(cyc), 32'd1024);
    check_eq("sweep_ready", {30'h0, if1.req_ready, if3.init_done}, 32'h3);

    xact(1, 1'b0, 3'b010, 12'h7FC, 32'h0, 32'h0, 1'b0, 1, "lw_init_top");
    xact(1, 1'b0, 3'b010, 12'h000, 32'h0, 32'h0, 1'b0, 1, "lw_init_0");

    xact(1, 1'b1, 3'b010, 12'h010, 32'h8000_80F1, 32'h0, 1'b0, 1, "sw_10");
    xact(1, 1'b0, 3'b000, 12'h010, 32'h0, 32'hFFFF_FFF1, 1'b0, 1, "lb_10");
    xact(1, 1'b0, 3'b100, 12'h011, 32'h0, 32'h0000_0080, 1'b0, 1, "lbu_11");
    xact(1, 1'b0, 3'b001, 12'h012, 32'h0, 32'hFFFF_8000, 1'b0, 1, "lh_12");
    xact(1, 1'b0, 3'b101, 12'h010, 32'h0, 32'h0000_80F1, 1'b0, 1, "lhu_10");

    xact(1, 1'b1, 3'b010, 12'h020, 32'h1122_3344, 32'h0, 1'b0, 1, "sw_20");
    xact(1, 1'b1, 3'b000, 12'h021, 32'h0000_00AB, 32'h0, 1'b0, 1, "sb_21");
    xact(1, 1'b0, 3'b010, 12'h020, 32'h0, 32'h1122_AB44, 1'b0, 1, "lw_20");

    xact(1, 1'b1, 3'b100, 12'h020, 32'h0000_00FF, 32'h0, 1'b1, 1, "sb_f3_100");
    xact(1, 1'b0, 3'b011, 12'h020, 32'h0, 32'h0, 1'b1, 1, "ld_f3_011");
    xact(1, 1'b0, 3'b010, 12'h020, 32'h0, 32'h1122_AB44, 1'b0, 1, "lw_20_kept");

    xact(1, 1'b1, 3'b010, 12'hFFC, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, "sw_ffc");
    xact(1, 1'b0, 3'b000, 12'hFFF, 32'h0, 32'hFFFF_FFDE, 1'b0, 1, "lb_fff");
    xact(1, 1'b0, 3'b101, 12'hFFE, 32'h0, 32'h0000_DEAD, 1'b0, 1, "lhu_ffe");

    xact(1, 1'b1, 3'b010, 12'h004, 32'hCAFE_BABE, 32'h0, 1'b0, 1, "sw_04");
`ifdef DMEM_MISALIGN_TRAP_EN
    xact(1, 1'b0, 3'b010, 12'h006, 32'h0, 32'h0, 1'b1, 1, "lw_06_mis");
    xact(1, 1'b1, 3'b001, 12'h005, 32'h0000_1234, 32'h0, 1'b1, 1, "sh_05_mis");
    xact(1, 1'b0, 3'b010, 12'h004, 32'h0, 32'hCAFE_BABE, 1'b0, 1, "lw_04_after");
`else
    xact(1, 1'b0, 3'b010, 12'h006, 32'h0, 32'hCAFE_BABE, 1'b0, 1, "lw_06_mis");
    xact(1, 1'b1, 3'b001, 12'h005, 32'h0000_1234, 32'h0, 1'b0, 1, "sh_05_mis");
    xact(1, 1'b0, 3'b010, 12'h004, 32'h0, 32'hCAFE_1234, 1'b0, 1, "lw_04_after");
`endif

    xact(3, 1'b1, 3'b010, 12'h010, 32'h5566_7788, 32'h0, 1'b0, 1, "rl3_sw_10");
    xact(3, 1'b0, 3'b010, 12'h010, 32'h0, 32'h5566_7788, 1'b0, 3, "rl3_lw_10");
    xact(3, 1'b1, 3'b100, 12'h010, 32'h0000_00FF, 32'h0, 1'b1, 1, "rl3_sb_f3_100");
    xact(3, 1'b0, 3'b010, 12'h010, 32'h0, 32'h5566_7788, 1'b0, 3, "rl3_lw_kept");
    xact(3, 1'b0, 3'b000, 12'h013, 32'h0, 32'h0000_0055, 1'b0, 3, "rl3_lb_13");

    // Load accepted on the latency-3 instance, then reset lands while it is still waiting.
    @(negedge clk);
    t_we = 1'b0; t_f3 = 3'b010; t_addr = 12'h010; t_wd = 32'h0;
    v3 = 1'b1;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    check_eq("rst_mid_in_wait", {30'h0, st3}, 32'h2);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (if3.rsp_valid) seen = 1'b1;
    end
    check_eq("rst_mid_no_rsp", {31'h0, seen}, 32'h0);
    check_eq("rst_mid_state", {28'h0, if3.init_done, if3.req_ready, st3}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    wait_init(cyc);
    check_eq("resweep_cycles", 32'(cyc), 32'd1024);
    xact(3, 1'b0, 3'b010, 12'h010, 32'h0, 32'h0, 1'b0, 3, "rl3_lw_10_cleared");
    xact(1, 1'b0, 3'b010, 12'h010, 32'h0, 32'h0, 1'b0, 1, "lw_10_cleared");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
